// File: rtl/s2mm_stream_writer_pkg.sv
// -----------------------------------------------------------------------------
// s2mm_stream_writer_pkg
// Shared definitions for the stream-to-memory-mapped writer:
//   - FSM state encoding
//   - AXI4 protocol constants (INCR burst, OKAY response, cache attributes)
//   - awsize helper derived from the data bus width
// -----------------------------------------------------------------------------
package s2mm_stream_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_CACHE_VAL  = 4'b0011;

  // Bytes per beat expressed as log2; only 32- and 64-bit buses are legal.
  function automatic logic [2:0] awsize_of(input int data_width);
    return (data_width == 64) ? 3'd3 : 3'd2;
  endfunction

endpackage

// File: rtl/s2mm_stream_writer.sv
// -----------------------------------------------------------------------------
// s2mm_stream_writer
// Writes an AXI4-Stream as fixed-length AXI4 INCR bursts into the buffer that
// sync_manager currently assigns, pulsing SM_writing once per accepted W beat.
// A private byte offset inside the buffer restarts on buffer change or when it
// reaches the buffer end.
//
// Ports:
//   SYS_aclk, SYS_reset          clock, synchronous active-high reset
//   S_AXIS_*                     input sample stream (tdata/tvalid/tready)
//   SM_log_length                buffer size = 2^SM_log_length bytes
//   SM_write_buffer              current buffer base address
//   SM_writing                   one pulse per accepted W beat
//   SM_error                     sticky, set on a non-OKAY write response
//   M_AXI_aw*/w*/b*              AXI4 write master channels
//
// Handshake rule used throughout: a transfer happens on a rising edge where
// both valid and ready are high; a raised valid is never withdrawn before its
// transfer except by reset.
// -----------------------------------------------------------------------------
module s2mm_stream_writer
  import s2mm_stream_writer_pkg::*;
#(
  parameter int MM_ADDR_WIDTH = 32,
  parameter int MM_DATA_WIDTH = 64,
  parameter int BURST_LEN     = 16
) (
  input  logic                       SYS_aclk,
  input  logic                       SYS_reset,
  input  logic [MM_DATA_WIDTH-1:0]   S_AXIS_tdata,
  input  logic                       S_AXIS_tvalid,
  output logic                       S_AXIS_tready,
  input  logic [4:0]                 SM_log_length,
  input  logic [MM_ADDR_WIDTH-1:0]   SM_write_buffer,
  output logic                       SM_writing,
  output logic [MM_ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic [7:0]                 M_AXI_awlen,
  output logic [2:0]                 M_AXI_awsize,
  output logic [1:0]                 M_AXI_awburst,
  output logic [3:0]                 M_AXI_awcache,
  output logic                       M_AXI_awvalid,
  input  logic                       M_AXI_awready,
  output logic [MM_DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [MM_DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                       M_AXI_wlast,
  output logic                       M_AXI_wvalid,
  input  logic                       M_AXI_wready,
  input  logic [1:0]                 M_AXI_bresp,
  input  logic                       M_AXI_bvalid,
  output logic                       M_AXI_bready,
  output logic                       SM_error
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [MM_ADDR_WIDTH-1:0] BURST_BYTES =
    MM_ADDR_WIDTH'(BURST_LEN * MM_DATA_WIDTH / 8);

  state_t                   r_state;
  state_t                   w_next;
  logic [BEAT_W-1:0]        r_beat;
  logic [MM_ADDR_WIDTH-1:0] r_offset;
  logic [MM_ADDR_WIDTH-1:0] r_base;
  logic [MM_ADDR_WIDTH-1:0] r_awaddr;
  logic                     r_error;

  logic                     w_wvalid;
  logic                     w_wlast;
  logic                     w_w_hs;
  logic [MM_ADDR_WIDTH-1:0] w_off_sel;
  logic [MM_ADDR_WIDTH-1:0] w_off_adv;
  logic [MM_ADDR_WIDTH-1:0] w_buf_size;

  // A new buffer from sync_manager restarts at its first byte; the same buffer
  // continues where the previous burst ended.
  assign w_off_sel  = (SM_write_buffer != r_base) ? '0 : r_offset;
  assign w_off_adv  = r_offset + BURST_BYTES;
  assign w_buf_size = MM_ADDR_WIDTH'(1) << SM_log_length;
  assign w_w_hs     = w_wvalid & M_AXI_wready;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (S_AXIS_tvalid)          w_next = ST_ADDR;
      ST_ADDR: if (M_AXI_awready)          w_next = ST_DATA;
      ST_DATA: if (w_w_hs && w_wlast)      w_next = ST_RESP;
      ST_RESP: if (M_AXI_bvalid)           w_next = ST_IDLE;
      default:                             w_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  // DATA is a straight pass-through: the stream and the W channel share one
  // handshake, so no buffering is needed and throughput is one beat per cycle.
  always_comb begin
    M_AXI_awvalid = 1'b0;
    w_wvalid      = 1'b0;
    S_AXIS_tready = 1'b0;
    M_AXI_bready  = 1'b0;
    w_wlast       = 1'b0;
    case (r_state)
      ST_ADDR: M_AXI_awvalid = 1'b1;
      ST_DATA: begin
        w_wvalid      = S_AXIS_tvalid;
        S_AXIS_tready = M_AXI_wready;
        w_wlast       = (r_beat == LAST_BEAT);
      end
      ST_RESP: M_AXI_bready = 1'b1;
      default: ;
    endcase
  end

  assign M_AXI_wvalid  = w_wvalid;
  assign M_AXI_wlast   = w_wlast;
  assign SM_writing    = w_w_hs;
  assign M_AXI_wdata   = S_AXIS_tdata;
  assign M_AXI_wstrb   = '1;
  assign M_AXI_awaddr  = r_awaddr;
  assign M_AXI_awlen   = 8'(BURST_LEN - 1);
  assign M_AXI_awsize  = awsize_of(MM_DATA_WIDTH);
  assign M_AXI_awburst = AXI_BURST_INCR;
  assign M_AXI_awcache = AXI_CACHE_VAL;
  assign SM_error      = r_error;

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset) begin
      r_beat   <= '0;
      r_offset <= '0;
      r_base   <= '0;
      r_awaddr <= '0;
      r_error  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && S_AXIS_tvalid) begin
        r_base   <= SM_write_buffer;
        r_offset <= w_off_sel;
        r_awaddr <= SM_write_buffer + w_off_sel;
      end

      if (r_state == ST_ADDR && M_AXI_awready) r_beat <= '0;
      else if (w_w_hs)                         r_beat <= r_beat + BEAT_W'(1);

      if (r_state == ST_RESP && M_AXI_bvalid) begin
        if (M_AXI_bresp != AXI_RESP_OKAY) r_error <= 1'b1;
        // Buffer size is a multiple of the burst size, so reaching the end
        // lands exactly on it; >= also covers a shrunken SM_log_length.
        r_offset <= (w_off_adv >= w_buf_size) ? '0 : w_off_adv;
      end
    end
  end

endmodule

// File: tb/tb_s2mm_stream_writer.sv
module tb_s2mm_stream_writer;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BL = 16;
  localparam int BB = BL * DW / 8;   // bytes per burst

  // ------------------------------------------------------------ clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            SYS_reset;
  logic [DW-1:0]   S_AXIS_tdata;
  logic            S_AXIS_tvalid;
  logic            S_AXIS_tready;
  logic [4:0]      SM_log_length;
  logic [AW-1:0]   SM_write_buffer;
  logic            SM_writing;
  logic [AW-1:0]   M_AXI_awaddr;
  logic [7:0]      M_AXI_awlen;
  logic [2:0]      M_AXI_awsize;
  logic [1:0]      M_AXI_awburst;
  logic [3:0]      M_AXI_awcache;
  logic            M_AXI_awvalid;
  logic            M_AXI_awready;
  logic [DW-1:0]   M_AXI_wdata;
  logic [DW/8-1:0] M_AXI_wstrb;
  logic            M_AXI_wlast;
  logic            M_AXI_wvalid;
  logic            M_AXI_wready;
  logic [1:0]      M_AXI_bresp;
  logic            M_AXI_bvalid;
  logic            M_AXI_bready;
  logic            SM_error;

  s2mm_stream_writer #(.MM_ADDR_WIDTH(AW), .MM_DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .SYS_aclk(clk), .SYS_reset(SYS_reset),
    .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
    .SM_log_length(SM_log_length), .SM_write_buffer(SM_write_buffer),
    .SM_writing(SM_writing),
    .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awlen(M_AXI_awlen), .M_AXI_awsize(M_AXI_awsize),
    .M_AXI_awburst(M_AXI_awburst), .M_AXI_awcache(M_AXI_awcache),
    .M_AXI_awvalid(M_AXI_awvalid), .M_AXI_awready(M_AXI_awready),
    .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb), .M_AXI_wlast(M_AXI_wlast),
    .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready),
    .M_AXI_bresp(M_AXI_bresp), .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bready(M_AXI_bready),
    .SM_error(SM_error)
  );

  // -------------------------------------------------------------- scoreboard
  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] sent_q[$];      // stream beats offered, in order
  logic [DW-1:0] got_w_q[$];     // W beats observed
  logic          got_last_q[$];
  logic [AW-1:0] got_aw_q[$];    // burst addresses observed
  logic          got_err_q[$];   // SM_error at each AW handshake
  logic          got_berr_q[$];  // SM_error one cycle after each B handshake
  int sm_cnt, hs_cnt, rule_bad;

  // scenario knobs
  int cfg_wr_mode;        // 0 always ready, 1 toggle, 2 random
  bit cfg_aw_rand;
  int cfg_tv_gap;         // percent chance of withholding tvalid
  int cfg_err_burst;
  int cfg_switch_burst;
  logic [AW-1:0] cfg_switch_addr;
  int cfg_abort_beats;

  // ----------------------------------------------------------------- drivers
  task automatic clear_cfg();
    cfg_wr_mode = 0; cfg_aw_rand = 0; cfg_tv_gap = 0; cfg_err_burst = -1;
    cfg_switch_burst = -1; cfg_switch_addr = '0; cfg_abort_beats = 0;
  endtask

  task automatic do_reset();
    S_AXIS_tvalid = 0; S_AXIS_tdata = '0; M_AXI_awready = 0; M_AXI_wready = 0;
    M_AXI_bvalid = 0; M_AXI_bresp = 2'b00;
    SYS_reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    SYS_reset = 0;
  endtask

  task automatic fill_random(input int n);
    sent_q.delete();
    for (int i = 0; i < n; i++) sent_q.push_back({$urandom, $urandom});
  endtask

  // Acts as stream source plus AXI write slave. Inputs are driven at the
  // falling edge, outputs observed 1 time unit later: what is seen then is
  // exactly what the next rising edge commits.
  task automatic run_bursts(input int nb);
    int idx, bdone, cyc, resp_wait;
    bit in_data, in_data_n, resp_pend, t_acc, b_acc, aborted;
    idx = 0; bdone = 0; cyc = 0; resp_wait = 0;
    in_data = 0; resp_pend = 0; t_acc = 0; b_acc = 0; aborted = 0;
    got_w_q.delete(); got_last_q.delete(); got_aw_q.delete();
    got_err_q.delete(); got_berr_q.delete();
    sm_cnt = 0; hs_cnt = 0; rule_bad = 0;
    while (bdone < nb && cyc < 3000 * nb && !aborted) begin
      @(negedge clk);
      cyc++;
      if (t_acc) begin S_AXIS_tvalid = 0; t_acc = 0; end
      if (b_acc) begin
        M_AXI_bvalid = 0; resp_pend = 0; b_acc = 0;
        got_berr_q.push_back(SM_error);
      end
      if (!S_AXIS_tvalid && idx < sent_q.size() && $urandom_range(0, 99) >= cfg_tv_gap) begin
        S_AXIS_tvalid = 1; S_AXIS_tdata = sent_q[idx];
      end
      case (cfg_wr_mode)
        0:       M_AXI_wready = 1;
        1:       M_AXI_wready = !M_AXI_wready;
        default: M_AXI_wready = 1'($urandom_range(0, 1));
      endcase
      M_AXI_awready = cfg_aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (resp_pend && !M_AXI_bvalid) begin
        if (resp_wait > 0) resp_wait--;
        else begin
          M_AXI_bvalid = 1;
          M_AXI_bresp  = (bdone == cfg_err_burst) ? 2'b10 : 2'b00;
        end
      end
      if (in_data && cfg_switch_burst >= 0 && got_aw_q.size() == cfg_switch_burst + 1)
        SM_write_buffer = cfg_switch_addr;
      #1;
      if (S_AXIS_tready !== (in_data & M_AXI_wready)) rule_bad++;
      if (M_AXI_wvalid !== (in_data & S_AXIS_tvalid)) rule_bad++;
      if (SM_writing !== (M_AXI_wvalid & M_AXI_wready)) rule_bad++;
      if (M_AXI_wvalid && M_AXI_wdata !== S_AXIS_tdata) rule_bad++;
      if (SM_writing === 1'b1) sm_cnt++;
      in_data_n = in_data;
      if (M_AXI_awvalid && M_AXI_awready) begin
        got_aw_q.push_back(M_AXI_awaddr); got_err_q.push_back(SM_error); in_data_n = 1;
      end
      if (S_AXIS_tvalid && S_AXIS_tready) begin idx++; t_acc = 1; end
      if (M_AXI_wvalid && M_AXI_wready) begin
        got_w_q.push_back(M_AXI_wdata); got_last_q.push_back(M_AXI_wlast); hs_cnt++;
        if (M_AXI_wlast) begin
          resp_pend = 1; resp_wait = $urandom_range(0, 2); in_data_n = 0;
        end
        if (cfg_abort_beats > 0 && got_w_q.size() == cfg_abort_beats) aborted = 1;
      end
      if (M_AXI_bvalid && M_AXI_bready) begin b_acc = 1; bdone++; end
      in_data = in_data_n;
    end
    if (!aborted) begin
      if (bdone < nb) begin
        vectors++; miscompares++;
        $display("FAIL timeout: %0d of %0d bursts completed", bdone, nb);
      end
      @(negedge clk);
      if (b_acc) got_berr_q.push_back(SM_error);
      S_AXIS_tvalid = 0; M_AXI_bvalid = 0; M_AXI_bresp = 2'b00;
    end
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    clear_cfg();
    SM_write_buffer = 32'h1E00_0000; SM_log_length = 5'd10;
    do_reset();
    #1;
    vectors++;
    if ({M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, S_AXIS_tready, SM_writing, SM_error} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got aw/w/b/t/wr/err=%b want 000000",
               {M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, S_AXIS_tready, SM_writing, SM_error});
    end
    vectors++;
    if ({M_AXI_awlen, M_AXI_awsize, M_AXI_awburst, M_AXI_awcache} !== {8'd15, 3'd3, 2'b01, 4'b0011}) begin
      miscompares++;
      $display("FAIL aw_constants: got len=%0d size=%0d burst=%b cache=%b want 15 3 01 0011",
               M_AXI_awlen, M_AXI_awsize, M_AXI_awburst, M_AXI_awcache);
    end
    vectors++;
    if (M_AXI_wstrb !== 8'hFF) begin
      miscompares++;
      $display("FAIL wstrb: got %h want ff", M_AXI_wstrb);
    end
  endtask

  // Expected burst address i for a fixed buffer: plain modular arithmetic.
  task automatic check_addrs(input string name, input logic [AW-1:0] exp_q[$]);
    vectors++;
    if (got_aw_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_count: got %0d bursts want %0d", name, got_aw_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_aw_q.size(); i++) begin
      vectors++;
      if (got_aw_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s_awaddr[%0d]: got %h want %h", name, i, got_aw_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic check_data(input string name, input int nb);
    int bad_d, bad_l;
    bad_d = 0; bad_l = 0;
    vectors++;
    if (got_w_q.size() != nb * BL) begin
      miscompares++;
      $display("FAIL %s_beats: got %0d want %0d", name, got_w_q.size(), nb * BL);
    end
    for (int i = 0; i < got_w_q.size() && i < sent_q.size(); i++) begin
      if (got_w_q[i] !== sent_q[i]) bad_d++;
      if (got_last_q[i] !== ((i % BL) == BL - 1)) bad_l++;
    end
    vectors++;
    if (bad_d != 0) begin miscompares++; $display("FAIL %s_wdata: %0d beats wrong want 0", name, bad_d); end
    vectors++;
    if (bad_l != 0) begin miscompares++; $display("FAIL %s_wlast: %0d beats wrong want 0", name, bad_l); end
    vectors++;
    if (sm_cnt != nb * BL) begin
      miscompares++; $display("FAIL %s_sm_writing: got %0d pulses want %0d", name, sm_cnt, nb * BL);
    end
    vectors++;
    if (rule_bad != 0) begin
      miscompares++; $display("FAIL %s_channel_rules: got %0d violations want 0", name, rule_bad);
    end
  endtask

  task automatic test_basic_burst();
    logic [AW-1:0] exp_q[$];
    clear_cfg();
    sent_q.delete();
    for (int i = 0; i < BL; i++) sent_q.push_back(DW'(i));
    for (int i = 0; i < BL; i++) sent_q.push_back({$urandom, $urandom});
    run_bursts(2);
    exp_q = '{32'h1E00_0000, 32'h1E00_0080};
    check_addrs("basic", exp_q);
    check_data("basic", 2);
  endtask

  task automatic test_offset_wrap();
    logic [AW-1:0] exp_q[$];
    clear_cfg(); cfg_aw_rand = 1; cfg_tv_gap = 20;
    do_reset();
    fill_random(9 * BL);
    run_bursts(9);
    for (int i = 0; i < 9; i++) exp_q.push_back(32'h1E00_0000 + AW'((i * BB) % 1024));
    check_addrs("wrap", exp_q);
    check_data("wrap", 9);
  endtask

  task automatic test_buffer_switch();
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] buf_of_burst, cur_base;
    int off;
    clear_cfg(); cfg_switch_burst = 2; cfg_switch_addr = 32'h1E00_0400;
    SM_write_buffer = 32'h1E00_0000;
    do_reset();
    fill_random(5 * BL);
    run_bursts(5);
    cur_base = '0; off = 0;
    for (int i = 0; i < 5; i++) begin
      buf_of_burst = (i <= 2) ? 32'h1E00_0000 : 32'h1E00_0400;
      if (buf_of_burst != cur_base) begin cur_base = buf_of_burst; off = 0; end
      exp_q.push_back(cur_base + AW'(off));
      off = (off + BB) % 1024;
    end
    check_addrs("switch", exp_q);
    check_data("switch", 5);
    SM_write_buffer = 32'h1E00_0000;
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] exp_q[$];
    clear_cfg(); cfg_wr_mode = 1; cfg_tv_gap = 30;
    do_reset();
    fill_random(3 * BL);
    run_bursts(3);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h1E00_0000 + AW'(i * BB));
    check_addrs("bp", exp_q);
    check_data("bp", 3);
    vectors++;
    if (hs_cnt != 3 * BL) begin
      miscompares++; $display("FAIL bp_handshakes: got %0d want %0d", hs_cnt, 3 * BL);
    end
  endtask

  task automatic test_random_geometry();
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] base;
    int lens[4] = '{7, 8, 9, 11};
    int lg;
    for (int r = 0; r < 3; r++) begin
      clear_cfg(); cfg_wr_mode = 2; cfg_aw_rand = 1; cfg_tv_gap = $urandom_range(0, 40);
      lg = lens[$urandom_range(0, 3)];
      base = {$urandom} & 32'hFFFF_F000;
      SM_write_buffer = base; SM_log_length = 5'(lg);
      do_reset();
      fill_random(6 * BL);
      run_bursts(6);
      exp_q.delete();
      for (int i = 0; i < 6; i++) exp_q.push_back(base + AW'((i * BB) % (1 << lg)));
      check_addrs("geom", exp_q);
      check_data("geom", 6);
    end
    SM_write_buffer = 32'h1E00_0000; SM_log_length = 5'd10;
  endtask

  task automatic test_error_response();
    logic exp_aw_err[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic exp_b_err[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    clear_cfg(); cfg_err_burst = 1;
    do_reset();
    fill_random(4 * BL);
    run_bursts(4);
    vectors++;
    if (got_berr_q.size() != 4 || got_err_q.size() != 4) begin
      miscompares++;
      $display("FAIL err_samples: got %0d/%0d want 4/4", got_berr_q.size(), got_err_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (got_berr_q[i] !== exp_b_err[i] || got_err_q[i] !== exp_aw_err[i]) begin
          miscompares++;
          $display("FAIL sm_error[%0d]: got after_b=%b at_aw=%b want %b %b",
                   i, got_berr_q[i], got_err_q[i], exp_b_err[i], exp_aw_err[i]);
        end
      end
    end
    vectors++;
    if (SM_error !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b want 1", SM_error); end
    do_reset();
    #1;
    vectors++;
    if (SM_error !== 1'b0) begin miscompares++; $display("FAIL err_cleared: got %b want 0", SM_error); end
  endtask

  task automatic test_reset_mid_burst();
    logic [AW-1:0] exp_q[$];
    clear_cfg();
    do_reset();
    fill_random(3 * BL);
    run_bursts(2);                   // offset now two bursts in
    cfg_abort_beats = 6;
    run_bursts(1);
    @(negedge clk);
    S_AXIS_tvalid = 1; M_AXI_wready = 1; M_AXI_awready = 1;
    #1;
    vectors++;
    if (M_AXI_wvalid !== 1'b1) begin
      miscompares++; $display("FAIL mid_burst_active: got wvalid=%b want 1", M_AXI_wvalid);
    end
    SYS_reset = 1;
    @(posedge clk);
    #1;
    vectors++;
    if ({M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, S_AXIS_tready, SM_writing} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_abandon: got aw/w/b/t/wr=%b want 00000",
               {M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, S_AXIS_tready, SM_writing});
    end
    @(negedge clk);
    SYS_reset = 0; S_AXIS_tvalid = 0;
    cfg_abort_beats = 0;
    fill_random(BL);
    run_bursts(1);
    exp_q = '{32'h1E00_0000};
    check_addrs("post_reset", exp_q);
    check_data("post_reset", 1);
  endtask

  // ------------------------------------------------------------------- main
  initial begin
    SYS_reset = 1; S_AXIS_tvalid = 0; S_AXIS_tdata = '0;
    SM_log_length = 5'd10; SM_write_buffer = 32'h1E00_0000;
    M_AXI_awready = 0; M_AXI_wready = 0; M_AXI_bvalid = 0; M_AXI_bresp = 2'b00;
    clear_cfg();
    test_reset();
    test_basic_burst();
    test_offset_wrap();
    test_buffer_switch();
    test_backpressure();
    test_random_geometry();
    test_error_response();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
